// File: rtl/carfield_pkg.sv
// Carfield reset-domain definitions shared by the per-domain warm-reset sequencer.
package carfield_pkg;

   localparam int unsigned NumRstDomains = 6;

   typedef enum logic [2:0] {
      RstDomPeriph     = 3'd0,
      RstDomSafety     = 3'd1,
      RstDomSecurity   = 3'd2,
      RstDomIntCluster = 3'd3,
      RstDomFpCluster  = 3'd4,
      RstDomL2         = 3'd5
   } carfield_rst_domains_e;

   typedef enum logic [2:0] {
      Idle    = 3'd0,
      Isolate = 3'd1,
      Reset   = 3'd2,
      Settle  = 3'd3,
      Release = 3'd4,
      Done    = 3'd5
   } rst_seq_state_e;

endpackage

// File: rtl/lzc.sv
// Trailing/leading zero counter with the common_cells lzc interface.
// MODE=0 counts trailing zeros, so cnt_o is the lowest set index.
module lzc #(
   parameter int unsigned WIDTH     = 2,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   logic found;

   always_comb begin
      cnt_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!found && in_i[MODE ? (WIDTH - 1 - i) : i]) begin
            cnt_o = CNT_WIDTH'(i);
            found = 1'b1;
         end
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/carfield_domain_rst_seq.sv
// Per-domain warm-reset sequencer: isolate, drain, pulse domain reset, settle,
// release isolation. One domain at a time, lowest pending index first.
module carfield_domain_rst_seq
   import carfield_pkg::*;
#(
   parameter int unsigned NumDomains    = NumRstDomains,
   parameter int unsigned RstHoldCycles = 16,
   parameter int unsigned DrainTimeout  = 1024,
   parameter int unsigned SettleCycles  = 2,
   localparam int unsigned IdxW         = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumDomains-1:0] rst_req_i,
   input  logic [NumDomains-1:0] isolated_i,
   output logic [NumDomains-1:0] isolate_o,
   output logic [NumDomains-1:0] domain_rst_no,
   output logic                  busy_o,
   output logic [IdxW-1:0]       active_idx_o,
   output logic                  done_o,
   output logic [NumDomains-1:0] timeout_o
);

   // Isolation handshake: isolate_o[i] is a level request held by this block;
   // isolated_i[i] is the cell's level acknowledge. A state waiting on the
   // acknowledge advances on the first cycle it sees the awaited level, or
   // after DrainTimeout cycles without it (flagging timeout_o[i]).

   localparam int unsigned MaxHD  = (RstHoldCycles > DrainTimeout) ? RstHoldCycles : DrainTimeout;
   localparam int unsigned MaxCnt = (MaxHD > SettleCycles) ? MaxHD : SettleCycles;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t DrainLoad  = cnt_t'(DrainTimeout - 1);
   localparam cnt_t HoldLoad   = cnt_t'(RstHoldCycles - 1);
   localparam cnt_t SettleLoad = cnt_t'(SettleCycles - 1);

   rst_seq_state_e state_q, state_d;

   logic [IdxW-1:0]       idx_q, idx_d;
   logic [IdxW-1:0]       sel_idx;
   logic                  sel_empty;
   cnt_t                  cnt_q, cnt_d;
   logic [NumDomains-1:0] pending_q, pending_d;
   logic [NumDomains-1:0] timeout_q, timeout_d;
   logic [NumDomains-1:0] isolate_q, isolate_d;
   logic [NumDomains-1:0] dom_rst_n_q, dom_rst_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [IdxW-1:0]       active_idx_q, active_idx_d;

   lzc #(
      .WIDTH     (NumDomains),
      .MODE      (1'b0),
      .CNT_WIDTH (IdxW)
   ) i_pending_lzc (
      .in_i    (pending_q),
      .cnt_o   (sel_idx),
      .empty_o (sel_empty)
   );

   // Next state, counter, pending and sticky timeout bookkeeping.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      timeout_d = timeout_q;

      unique case (state_q)
         Idle: begin
            if (!sel_empty) begin
               idx_d              = sel_idx;
               pending_d[sel_idx] = 1'b0;
               timeout_d[sel_idx] = 1'b0;
               state_d            = Isolate;
            end
         end
         Isolate: begin
            if (isolated_i[idx_q]) begin
               state_d = Reset;
            end else if (cnt_q == '0) begin
               timeout_d[idx_q] = 1'b1;
               state_d          = Reset;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         Reset: begin
            if (cnt_q == '0) state_d = Settle;
            else             cnt_d   = cnt_q - cnt_t'(1);
         end
         Settle: begin
            if (cnt_q == '0) state_d = Release;
            else             cnt_d   = cnt_q - cnt_t'(1);
         end
         Release: begin
            if (!isolated_i[idx_q]) begin
               state_d = Done;
            end else if (cnt_q == '0) begin
               timeout_d[idx_q] = 1'b1;
               state_d          = Done;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         Done:    state_d = Idle;
         default: state_d = Idle;
      endcase

      // No state loops onto itself, so a state change is exactly a state entry.
      if (state_d != state_q) begin
         unique case (state_d)
            Isolate, Release: cnt_d = DrainLoad;
            Reset:            cnt_d = HoldLoad;
            Settle:           cnt_d = SettleLoad;
            default:          cnt_d = '0;
         endcase
      end

      // A new request beats the clear on entry, so the domain is served again.
      pending_d = pending_d | rst_req_i;
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      isolate_d    = '0;
      dom_rst_n_d  = '1;
      busy_d       = (state_d != Idle);
      done_d       = (state_d == Done);
      active_idx_d = busy_d ? idx_d : '0;
      if (state_d inside {Isolate, Reset, Settle}) isolate_d[idx_d] = 1'b1;
      if (state_d == Reset) dom_rst_n_d[idx_d] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= Idle;
         idx_q        <= '0;
         cnt_q        <= '0;
         pending_q    <= '0;
         timeout_q    <= '0;
         isolate_q    <= '0;
         dom_rst_n_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         active_idx_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         timeout_q    <= timeout_d;
         isolate_q    <= isolate_d;
         dom_rst_n_q  <= dom_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         active_idx_q <= active_idx_d;
      end
   end

   assign isolate_o     = isolate_q;
   assign domain_rst_no = dom_rst_n_q;
   assign busy_o        = busy_q;
   assign active_idx_o  = active_idx_q;
   assign done_o        = done_q;
   assign timeout_o     = timeout_q;

endmodule

// File: doc/carfield_domain_rst_seq.md
# carfield_domain_rst_seq

Per-domain warm-reset sequencer for the Carfield reset domains (peripherals, safety island, security island, integer cluster, FP cluster, L2). It sits between the Carfield control registers, which issue reset requests, and the per-domain AXI isolation cells and reset synchronizers that consume its outputs. For each request it isolates the domain's AXI ports, waits for them to drain, pulses the domain reset for a fixed time, then releases isolation. Domains are served one at a time.

## Interface
- NumDomains, 6: number of reset domains; index = carfield_rst_domains_e value.
- RstHoldCycles, 16: cycles domain reset is held low; must be ≥1.
- DrainTimeout, 1024: max cycles waited for isolated_i to rise or fall; must be ≥1.
- SettleCycles, 2: cycles between reset release and isolation release; must be ≥1.
- clk_i  in  1  system clock; the single clock.
- rst_ni  in  1  asynchronous active-low reset.
- rst_req_i  in  NumDomains  one-cycle request pulse per domain, from control registers.
- isolated_i  in  NumDomains  isolation-cell status: 1 = domain ports isolated and drained.
- isolate_o  out  NumDomains  isolation request to the domain's AXI isolate cell.
- domain_rst_no  out  NumDomains  active-low domain reset, registered and glitch-free.
- busy_o  out  1  sequencer not idle.
- active_idx_o  out  $clog2(NumDomains)  domain currently being sequenced; 0 when idle.
- done_o  out  1  one-cycle pulse when a sequence completes.
- timeout_o  out  NumDomains  sticky drain-timeout flag per domain.

## Operation
- Reset values: isolate_o='0, domain_rst_no='0 (all domains held in reset while rst_ni is low), busy_o=0, active_idx_o=0, done_o=0, timeout_o='0, pending='0, FSM=Idle.
- After rst_ni deasserts, domain_rst_no goes to all ones on the first clock edge. No isolation is applied at this point.
- pending[i] is set by rst_req_i[i]. It is cleared when domain i enters Isolate. If a set and a clear hit the same bit in the same cycle, the set wins, and domain i is sequenced again later.
- Arbitration: in Idle, the lowest set pending index is selected via lzc.
- FSM states and transitions:
  - Idle: if pending≠0, latch the index, go to Isolate.
  - Isolate: isolate_o[idx]=1. On isolated_i[idx]=1, go to Reset. If the counter reaches DrainTimeout, set timeout_o[idx] and go to Reset anyway.
  - Reset: domain_rst_no[idx]=0 for exactly RstHoldCycles cycles, then go to Settle.
  - Settle: domain_rst_no[idx]=1. Wait SettleCycles cycles, then go to Release.
  - Release: isolate_o[idx]=0. On isolated_i[idx]=0 or at DrainTimeout (which sets timeout_o[idx]), go to Done.
  - Done: done_o=1 for one cycle, then go to Idle.
- timeout_o[i] clears only on rst_ni or when domain i next enters Isolate.
- One shared down-counter, reloaded on every state entry. Width is $clog2(max(RstHoldCycles,DrainTimeout,SettleCycles)+1). It must never wrap.
- Outputs for domains other than idx are never disturbed: their isolate_o stays 0 and their domain_rst_no stays 1.
- busy_o=1 in every state except Idle.

## Timing
- All outputs are registered; no combinational input-to-output path.
- rst_req_i[i] pulse in cycle 0:
  - pending[i] is set in cycle 1.
  - The FSM enters Isolate and isolate_o[i]=1 in cycle 2.
- Isolation to reset: isolated_i[i] seen high in cycle k gives domain_rst_no[i]=0 in cycles k+1 … k+RstHoldCycles.
- Reset release to isolation release: domain_rst_no[i] returns to 1 in cycle k+RstHoldCycles+1. isolate_o[i] drops SettleCycles cycles later.
- Release to next domain: isolated_i[i] seen low in cycle m gives done_o=1 in cycle m+1, Idle in cycle m+2, and the next pending domain in Isolate in cycle m+3.
- Timeout: when a wait state lasts DrainTimeout cycles without the awaited isolated_i level, the state is left on the next edge.
- rst_ni asserted mid-sequence: all outputs take their reset values asynchronously, including domain_rst_no='0. Pending requests are lost.

## Structure
- Add to carfield_pkg:
  - NumRstDomains = 6;
  - an rst_seq_state_e enum (Idle, Isolate, Reset, Settle, Release, Done) for waveform visibility.
- Index priority uses common_cells lzc. No other sub-module.

## Test plan
- Single request: pulse rst_req_i[3] in cycle 0; isolated_i[3] follows isolate_o after 5 cycles.
  - Required: isolate_o[3] high from cycle 2.
  - Required: domain_rst_no[3] low for exactly 16 cycles, then isolate_o[3] low 2 cycles after release.
  - Required: done_o pulses once; all other outputs are unchanged.
- Drain timeout with DrainTimeout=8: isolated_i[1] never rises.
  - Required: reset is asserted 8 cycles after isolate_o[1] rises.
  - Required: timeout_o[1]=1 and stays set after Done.
- Simultaneous requests: pulse bits 5, 2 and 0 together.
  - Required: domains are sequenced in order 0, 2, 5, with active_idx_o tracking each one.
  - Required: exactly three done_o pulses.
- Re-request: pulse rst_req_i[4] again while domain 4 is in Reset.
  - Required: a second full sequence runs for domain 4 after Done.
- Reset mid-sequence: drop rst_ni during Reset.
  - Required: all outputs go to their reset values immediately, and the pending request is lost.
  - Required: after release, domain_rst_no is all ones and the FSM is Idle.
